// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants, FSM states and helpers for the program loader
package imem_loader_pkg;

    localparam int ISIZE_DEF = 18;
    localparam int DSIZE_DEF = 16;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // States in which a frame is open and a silent line must eventually fail.
    function automatic logic in_frame(state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CSUM};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction RAM write port out
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ISIZE = ISIZE_DEF,
    parameter int DSIZE = DSIZE_DEF
);
    logic [7:0]       Byte_In;
    logic             Byte_Valid_In;
    logic             Wr_En_Out;
    logic [DSIZE-1:0] Wr_Add_Out;
    logic [ISIZE-1:0] Wr_Data_Out;

    modport master (
        input  Byte_In, Byte_Valid_In,
        output Wr_En_Out, Wr_Add_Out, Wr_Data_Out
    );

    modport slave (
        output Byte_In, Byte_Valid_In,
        input  Wr_En_Out, Wr_Add_Out, Wr_Data_Out
    );
endinterface

// File: rtl/imem_loader_timeout.sv
// rtl/imem_loader_timeout.sv - idle-cycle counter with clear, enable and expiry
module loader_timeout #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // A clear in the expiry cycle suppresses the expiry: the byte wins.
    assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i || !en_i) begin
            cnt_q <= '0;
        end else if (!expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - frames UART bytes into 18-bit words and writes them to instruction RAM
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ISIZE     = ISIZE_DEF,
    parameter int DSIZE     = DSIZE_DEF,
    parameter int MEM_DEPTH = 1024,
    parameter int TIMEOUT   = 65535
) (
    input  logic             Clk_In,
    input  logic             Rst_In,
    imem_loader_if.master    bus,
    output logic             Cpu_Hold_Out,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic             Err_Out,
    output logic [DSIZE-1:0] Word_Cnt_Out
);
    localparam logic [DSIZE:0] DEPTH_W = (DSIZE + 1)'(MEM_DEPTH);

    state_t           state_q;
    logic [7:0]       len_hi_q, csum_q;
    logic [1:0]       b0_q;
    logic [7:0]       b1_q;
    logic [DSIZE-1:0] len_q, addr_q, word_cnt_q, wr_add_q;
    logic [ISIZE-1:0] wr_data_q;
    logic             wr_en_q, hold_q, busy_q, done_q, err_q;

    logic [7:0]       byte_d;
    logic             strobe_d, tmo_expired;
    logic [DSIZE-1:0] len_d;
    logic [ISIZE-1:0] word_d;

    assign byte_d   = bus.Byte_In;
    assign strobe_d = bus.Byte_Valid_In;
    assign len_d    = DSIZE'({len_hi_q, byte_d});
    assign word_d   = ISIZE'({b0_q, b1_q, byte_d});

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i     (Clk_In),
        .rst_i     (Rst_In),
        .en_i      (in_frame(state_q)),
        .clr_i     (strobe_d),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge Clk_In) begin
        if (Rst_In) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            csum_q     <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            wr_add_q   <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            // The write issued last cycle is now committed; count it.
            if (wr_en_q) begin
                addr_q     <= addr_q + 1'b1;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (tmo_expired) begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else if (strobe_d) begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (byte_d == SYNC_BYTE) begin
                            state_q    <= S_LEN_HI;
                            busy_q     <= 1'b1;
                            hold_q     <= 1'b1;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            addr_q     <= '0;
                            csum_q     <= '0;
                            word_cnt_q <= '0;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi_q <= byte_d;
                        csum_q   <= csum_q + byte_d;
                        state_q  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_q  <= len_d;
                        csum_q <= csum_q + byte_d;
                        if ({1'b0, len_d} > DEPTH_W) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (len_d == '0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_B0;
                        end
                    end
                    S_B0: begin
                        b0_q    <= byte_d[1:0];
                        csum_q  <= csum_q + byte_d;
                        state_q <= S_B1;
                    end
                    S_B1: begin
                        b1_q    <= byte_d;
                        csum_q  <= csum_q + byte_d;
                        state_q <= S_B2;
                    end
                    S_B2: begin
                        csum_q    <= csum_q + byte_d;
                        wr_en_q   <= 1'b1;
                        wr_add_q  <= addr_q;
                        wr_data_q <= word_d;
                        state_q   <= (addr_q == len_q - 1'b1) ? S_CSUM : S_B0;
                    end
                    S_CSUM: begin
                        busy_q <= 1'b0;
                        if (byte_d == csum_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.Wr_En_Out   = wr_en_q;
    assign bus.Wr_Add_Out  = wr_add_q;
    assign bus.Wr_Data_Out = wr_data_q;
    assign Cpu_Hold_Out    = hold_q;
    assign Busy_Out        = busy_q;
    assign Done_Out        = done_q;
    assign Err_Out         = err_q;
    assign Word_Cnt_Out    = word_cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;
    localparam int MEM_DEPTH = 1024;
    localparam int TIMEOUT   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold, busy, done, err;
    logic [15:0] wcnt;

    imem_loader_if #(.ISIZE(18), .DSIZE(16)) bus ();

    imem_loader #(.ISIZE(18), .DSIZE(16), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk_In       (clk),
        .Rst_In       (rst),
        .bus          (bus),
        .Cpu_Hold_Out (hold),
        .Busy_Out     (busy),
        .Done_Out     (done),
        .Err_Out      (err),
        .Word_Cnt_Out (wcnt)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: tracks byte position inside the frame rather than a state machine.
    bit          m_active, m_busy, m_hold, m_done, m_err, m_wr_en;
    int          m_pos, m_len, m_idle, m_cnt;
    logic [7:0]  m_sum;
    logic [7:0]  m_grp [3];
    logic [15:0] m_wr_add;
    logic [17:0] m_wr_data;

    task automatic model_step(input logic r, input logic v, input logic [7:0] b);
        int k;
        if (r) begin
            m_active = 0; m_busy = 0; m_hold = 0; m_done = 0; m_err = 0; m_wr_en = 0;
            m_pos = 0; m_len = 0; m_idle = 0; m_cnt = 0; m_sum = 0;
            m_wr_add = 0; m_wr_data = 0;
            return;
        end
        if (m_wr_en) m_cnt++;
        m_wr_en = 0;
        if (m_active && !v) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_active = 0; m_err = 1; m_busy = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (!m_active) begin
                if (b == 8'hA5) begin
                    m_active = 1; m_pos = 0; m_sum = 0; m_len = 0; m_cnt = 0;
                    m_busy = 1; m_hold = 1; m_done = 0; m_err = 0;
                end
            end else begin
                m_pos++;
                k = m_pos - 3;
                if (m_pos == 1) begin
                    m_len = b * 256;
                    m_sum += b;
                end else if (m_pos == 2) begin
                    m_len += b;
                    m_sum += b;
                    if (m_len > MEM_DEPTH) begin
                        m_active = 0; m_err = 1; m_busy = 0;
                    end
                end else if (k < 3 * m_len) begin
                    m_sum += b;
                    m_grp[k % 3] = b;
                    if (k % 3 == 2) begin
                        m_wr_en   = 1;
                        m_wr_add  = 16'(k / 3);
                        m_wr_data = {m_grp[0][1:0], m_grp[1], m_grp[2]};
                    end
                end else begin
                    m_active = 0; m_busy = 0;
                    if (b == m_sum) begin
                        m_done = 1; m_hold = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    endtask

    bit          chk_en = 0;
    bit          prev_wr = 0;
    logic [15:0] log_add [$];
    logic [17:0] log_data[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("hold", hold, m_hold);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("wr_en", bus.Wr_En_Out, m_wr_en);
            chk("wr_add", bus.Wr_Add_Out, m_wr_add);
            chk("wr_data", bus.Wr_Data_Out, m_wr_data);
            chk("word_cnt", wcnt, m_cnt);
            chk("wr_spacing", prev_wr && bus.Wr_En_Out, 0);
            if (bus.Wr_En_Out) begin
                log_add.push_back(bus.Wr_Add_Out);
                log_data.push_back(bus.Wr_Data_Out);
            end
        end
        prev_wr = bus.Wr_En_Out;
    end

    task automatic cycle(input logic v, input logic [7:0] b);
        bus.Byte_Valid_In = v;
        bus.Byte_In       = b;
        @(posedge clk);
        #1;
        model_step(rst, v, b);
        chk_en = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b);
        idle($urandom_range(0, 2));
        cycle(1'b1, b);
    endtask

    task automatic send_frame(input int n, input bit bad);
        logic [15:0] nn;
        logic [7:0]  s, x;
        nn = 16'(n);
        s  = nn[15:8] + nn[7:0];
        send(8'hA5);
        send(nn[15:8]);
        send(nn[7:0]);
        for (int i = 0; i < 3 * n; i++) begin
            x = 8'($urandom);
            s += x;
            send(x);
        end
        send(bad ? s + 8'h01 : s);
    endtask

    int nlog;

    initial begin
        bus.Byte_Valid_In = 1'b0;
        bus.Byte_In       = 8'h00;
        rst = 1'b1;
        repeat (3) cycle(1'b0, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_hold", hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_en", bus.Wr_En_Out, 0);
        chk("rst_cnt", wcnt, 0);
        rst = 1'b0;

        send(8'h00); send(8'hFF); send(8'h12);
        chk("garbage_busy", busy, 0);
        chk("garbage_hold", hold, 0);

        // Nominal two-word load.
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h01); send(8'hA1); send(8'h00);
        send(8'h00); send(8'h04); send(8'h00);
        send(8'hA8);
        idle(3);
        chk("nom_nwr", log_add.size(), 2);
        chk("nom_add0", log_add[0], 16'd0);
        chk("nom_data0", log_data[0], 18'h1A100);
        chk("nom_add1", log_add[1], 16'd1);
        chk("nom_data1", log_data[1], 18'h00400);
        chk("nom_done", done, 1);
        chk("nom_hold", hold, 0);
        chk("nom_cnt", wcnt, 2);
        chk("model_done", m_done, 1);
        chk("model_cnt", m_cnt, 2);

        // Same frame, bad checksum.
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h01); send(8'hA1); send(8'h00);
        send(8'h00); send(8'h04); send(8'h00);
        send(8'hA9);
        idle(3);
        chk("bad_nwr", log_add.size(), 4);
        chk("bad_err", err, 1);
        chk("bad_done", done, 0);
        chk("bad_hold", hold, 1);

        // Zero length.
        nlog = log_add.size();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        chk("zero_done", done, 1);
        chk("zero_nwr", log_add.size(), nlog);

        // Oversize length 0x0401: error right after LEN_LO.
        cycle(1'b1, 8'hA5); cycle(1'b1, 8'h04); cycle(1'b1, 8'h01);
        chk("over_err", err, 1);
        chk("over_busy", busy, 0);
        send(8'h01); send(8'h02); send(8'h03);
        chk("over_nwr", log_add.size(), nlog);

        // Timeout expiry.
        cycle(1'b1, 8'hA5); cycle(1'b1, 8'h00); cycle(1'b1, 8'h01); cycle(1'b1, 8'h03);
        idle(TIMEOUT - 1);
        chk("tmo_before", err, 0);
        idle(1);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_hold", hold, 1);

        // Byte on the expiry cycle wins; frame then completes.
        cycle(1'b1, 8'hA5); cycle(1'b1, 8'h00); cycle(1'b1, 8'h01); cycle(1'b1, 8'h03);
        idle(TIMEOUT - 1);
        cycle(1'b1, 8'h00);
        chk("win_err", err, 0);
        chk("win_busy", busy, 1);
        send(8'h07); send(8'h0B);
        idle(2);
        chk("win_done", done, 1);
        chk("win_last_data", log_data[log_data.size() - 1], 18'h30007);
        chk("win_last_add", log_add[log_add.size() - 1], 16'd0);

        // Reset after B1 of word 0.
        nlog = log_add.size();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h02); send(8'h33);
        rst = 1'b1;
        cycle(1'b1, 8'h44);
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_hold", hold, 0);
        chk("mid_done", done, 0);
        chk("mid_add", bus.Wr_Add_Out, 0);
        idle(3);
        chk("mid_nwr", log_add.size(), nlog);

        // Random frames, checked every cycle by the model.
        for (int f = 0; f < 30; f++) begin
            logic [7:0] g;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send(g);
            end
            send_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            idle($urandom_range(1, 4));
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
